serial_subtractor_42_15: RTL

//  Digit-serial unsigned subtractor: Diff = A - zero_extend(B), 42-bit minuend, 15-bit subtrahend.

---
 rtl/serial_subtractor_42_15.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor_42_15.sv
// Digit-serial unsigned subtractor: Diff = A - zero_extend(B), DIGIT bits per clock.
// Borrow ripples between digits through a single flop; valid/ready on both sides.
module serial_subtractor_42_15 #(
    parameter int A_WIDTH = 42,
    parameter int B_WIDTH = 15,
    parameter int DIGIT   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH:0]   Diff
);

    localparam int NUM_DIGITS = A_WIDTH / DIGIT;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    generate
        if (A_WIDTH % DIGIT != 0) begin : g_badDigit
            $error("A_WIDTH must be a multiple of DIGIT");
        end
        if (B_WIDTH > A_WIDTH) begin : g_badWidth
            $error("B_WIDTH must not exceed A_WIDTH");
        end
        if (NUM_DIGITS < 2) begin : g_tooFewDigits
            $error("A_WIDTH must span at least two digits");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [A_WIDTH-1:0] r_a;
    logic [A_WIDTH-1:0] r_b;
    logic [A_WIDTH-1:0] r_res;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [A_WIDTH:0]   r_diff;

    logic [A_WIDTH-1:0] w_bExt;
    logic [DIGIT:0]     w_digitDiff;
    logic               w_lastDigit;
    logic               w_accept;

    assign w_bExt      = A_WIDTH'(B);
    assign w_lastDigit = (r_cnt == CNT_W'(NUM_DIGITS - 1));
    assign w_accept    = in_valid && (r_state == S_IDLE);

    // The low digit of the shifting operands is always the one being processed;
    // bit DIGIT of the widened difference doubles as the outgoing borrow.
    assign w_digitDiff = {1'b0, r_a[DIGIT-1:0]}
                       - {1'b0, r_b[DIGIT-1:0]}
                       - {{DIGIT{1'b0}}, r_borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (w_lastDigit) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Result digits enter from the top so after NUM_DIGITS shifts they sit in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
        end else if (w_accept) begin
            r_a      <= A;
            r_b      <= w_bExt;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_res    <= {w_digitDiff[DIGIT-1:0], r_res[A_WIDTH-1:DIGIT]};
            r_borrow <= w_digitDiff[DIGIT];
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_lastDigit) begin
                r_diff <= {w_digitDiff[DIGIT], w_digitDiff[DIGIT-1:0], r_res[A_WIDTH-1:DIGIT]};
            end
        end
    end

    assign Diff = r_diff;

endmodule
